// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: TMDS channel deserialiser, control-token word aligner and 8b/10b decoder (ports clk resetn sin -> vd cd vde word_stb locked; `TMDS_SLIP_CNT_EN adds slip_cnt)
module tmds_channel_decoder #(
  parameter int LOCK_COUNT    = 8,
  parameter int TIMEOUT_WORDS = 1024
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sin,
  output logic [7:0] vd,
  output logic [1:0] cd,
  output logic       vde,
  output logic       word_stb,
  output logic       locked
`ifdef TMDS_SLIP_CNT_EN
  ,
  output logic [15:0] slip_cnt
`endif
);
  localparam logic [7:0]  LC = 8'(LOCK_COUNT);
  localparam logic [15:0] TO = 16'(TIMEOUT_WORDS);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t      state_q, state_d;
  logic [9:0]  sr_q, sr_d;
  logic [3:0]  ph_q, ph_d;
  logic [7:0]  mc_q, mc_d;
  logic [15:0] gap_q, gap_d, gap_inc;
  logic [7:0]  vd_q, vd_d, dd, dec;
  logic [1:0]  cd_q, cd_d, tok_cd;
  logic        vde_q, vde_d, stb_q, stb_d, locked_q, is_tok, bnd;
  always_comb begin
    sr_d    = {sin, sr_q[9:1]};
    is_tok  = sr_d inside {10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    tok_cd  = sr_d == 10'b1101010100 ? 2'd0 :
              sr_d == 10'b0010101011 ? 2'd1 :
              sr_d == 10'b0101010100 ? 2'd2 : 2'd3;
    dd      = sr_d[9] ? ~sr_d[7:0] : sr_d[7:0];
    dec     = 8'd0;
    dec[0]  = dd[0];
    for (int i = 1; i < 8; i++) dec[i] = dd[i] ^ dd[i-1] ^ ~sr_d[8];
    bnd     = ph_q == 4'd9;
    gap_inc = gap_q == 16'hFFFF ? gap_q : gap_q + 16'd1;
    state_d = state_q;
    ph_d    = bnd ? 4'd0 : ph_q + 4'd1;
    mc_d    = mc_q;
    gap_d   = gap_q;
    vd_d    = vd_q;
    cd_d    = cd_q;
    vde_d   = vde_q;
    stb_d   = 1'b0;
    if (state_q == HUNT) begin
      ph_d = 4'd0;
      if (is_tok) begin
        mc_d    = 8'd1;
        state_d = VERIFY;
      end
    end else if (bnd && state_q == VERIFY) begin
      mc_d    = is_tok ? mc_q + 8'd1 : 8'd0;
      state_d = !is_tok ? HUNT : (mc_q + 8'd1 == LC) ? LOCKED : VERIFY;
      gap_d   = (is_tok && mc_q + 8'd1 == LC) ? 16'd0 : gap_q;
    end else if (bnd) begin
      gap_d   = is_tok ? 16'd0 : gap_inc;
      state_d = (!is_tok && gap_inc == TO) ? HUNT : LOCKED;
      mc_d    = (!is_tok && gap_inc == TO) ? 8'd0 : mc_q;
      stb_d   = is_tok || gap_inc != TO;
      vde_d   = stb_d ? !is_tok : vde_q;
      cd_d    = (stb_d && is_tok) ? tok_cd : cd_q;
      vd_d    = !stb_d ? vd_q : is_tok ? 8'd0 : dec;
    end
  end
`ifdef TMDS_SLIP_CNT_EN
  logic [15:0] slip_q, slip_d;
  always_comb slip_d = (state_q == LOCKED && !bnd && is_tok && slip_q != 16'hFFFF) ? slip_q + 16'd1 : slip_q;
  always_ff @(posedge clk) slip_q <= !resetn ? 16'd0 : slip_d;
  assign slip_cnt = slip_q;
`endif
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= HUNT;
      sr_q     <= '0;
      ph_q     <= '0;
      mc_q     <= '0;
      gap_q    <= '0;
      vd_q     <= '0;
      cd_q     <= '0;
      vde_q    <= 1'b0;
      stb_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      ph_q     <= ph_d;
      mc_q     <= mc_d;
      gap_q    <= gap_d;
      vd_q     <= vd_d;
      cd_q     <= cd_d;
      vde_q    <= vde_d;
      stb_q    <= stb_d;
      locked_q <= state_d == LOCKED;
    end
  end
  assign vd       = vd_q;
  assign cd       = cd_q;
  assign vde      = vde_q;
  assign word_stb = stb_q;
  assign locked   = locked_q;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed self-checking bench for tmds_channel_decoder
module tb_tmds_channel_decoder;
  logic       clk = 1'b0, resetn = 1'b0, sin = 1'b0;
  logic [7:0] vd;
  logic [1:0] cd;
  logic       vde, word_stb, locked;
`ifdef TMDS_SLIP_CNT_EN
  logic [15:0] slip_cnt;
`endif
  tmds_channel_decoder dut (
    .clk(clk), .resetn(resetn), .sin(sin), .vd(vd), .cd(cd), .vde(vde),
    .word_stb(word_stb), .locked(locked)
`ifdef TMDS_SLIP_CNT_EN
    , .slip_cnt(slip_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int bi; logic [7:0] vd; logic [1:0] cd; logic vde;} stb_t;
  stb_t       sq[$];
  int         n_chk = 0, n_fail = 0, nb = 0, lock_bit = -1, fall_bit = -1, disp = 0;
  logic       lk_prev = 1'b0, lost = 1'b0;
  logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    stb_t s;
    sin = b;
    @(negedge clk);
    if (word_stb) begin
      s.bi = nb; s.vd = vd; s.cd = cd; s.vde = vde;
      sq.push_back(s);
    end
    if (locked && !lk_prev) lock_bit = nb;
    if (!locked && lk_prev) begin lost = 1'b1; fall_bit = nb; end
    lk_prev = locked;
    nb++;
  endtask
  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) send_bit(w[i]);
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    sin    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", {vd, cd, vde, word_stb, locked}, 0);
    resetn   = 1'b1;
    nb       = 0;
    lock_bit = -1;
    fall_bit = -1;
    lk_prev  = 1'b0;
    lost     = 1'b0;
    sq.delete();
  endtask
  function automatic logic [9:0] enc(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] q;
    int n1 = 0, n1q = 0, n0q;
    for (int i = 0; i < 8; i++) n1 += int'(d[i]);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    for (int i = 0; i < 8; i++) n1q += int'(qm[i]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      disp += qm[8] ? n1q - n0q : n0q - n1q;
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp += -2 * int'(!qm[8]) + n1q - n0q;
    end
    return q;
  endfunction
  initial begin
    int k;
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 12; i++) send_word(tok[0]);
    send_word(10'b0100000000);
    chk("align_lock_bit", lock_bit, 82);
    chk("align_locked", locked, 1);
    chk("align_nstb", sq.size(), 5);
    for (int i = 0; i < sq.size() && i < 5; i++) begin
      chk("align_stb_spacing", sq[i].bi, 92 + 10 * i);
      chk("align_word", {sq[i].vde, sq[i].cd, sq[i].vd}, i < 4 ? 11'h000 : 11'h400);
    end
    sq.delete();
    send_word(10'b1000000000);
    send_word(10'b0100000000);
    for (int i = 0; i < 4; i++) send_word(tok[i]);
    chk("dec_nstb", sq.size(), 6);
    if (sq.size() == 6) begin
      chk("dec_ff", {sq[0].vde, sq[0].vd}, 9'h1FF);
      chk("dec_00", {sq[1].vde, sq[1].vd}, 9'h100);
      for (int i = 0; i < 4; i++) chk("ctl_token", {sq[i+2].vde, sq[i+2].cd}, 3'(i));
    end
    sq.delete();
    disp = 0;
    for (int b = 0; b < 256; b++) begin
      if (b % 32 == 0) send_word(tok[0]);
      send_word(enc(8'(b)));
    end
    k = 0;
    foreach (sq[i]) if (sq[i].vde) begin
      chk("byte_loop", sq[i].vd, k);
      k++;
    end
    chk("byte_count", k, 256);
    do_reset();
    for (int i = 0; i < 5; i++) send_word(tok[0]);
    send_word(10'b0100000000);
    chk("vfail_locked", locked, 0);
    chk("vfail_nstb", sq.size(), 0);
    for (int i = 0; i < 8; i++) send_word(tok[0]);
    chk("vfail_relock_bit", lock_bit, 139);
    chk("vfail_nstb_after", sq.size(), 0);
    do_reset();
    for (int i = 0; i < 8; i++) send_word(tok[0]);
    chk("to_lock_bit", lock_bit, 79);
    sq.delete();
    for (int i = 0; i < 1023; i++) send_word(10'b0100000000);
    chk("to_locked_1023", locked, 1);
    send_word(10'b0100000000);
    chk("to_locked_1024", locked, 0);
    chk("to_fall_bit", fall_bit, 10319);
    chk("to_nstb", sq.size(), 1023);
    if (sq.size() > 0) chk("to_last_stb", sq[$].bi, 10309);
    for (int i = 0; i < 8; i++) send_word(tok[0]);
    chk("to_relock_bit", lock_bit, 10399);
`ifdef TMDS_SLIP_CNT_EN
    do_reset();
    chk("slip_reset", slip_cnt, 0);
    for (int i = 0; i < 8; i++) send_word(tok[0]);
    chk("slip_none", slip_cnt, 0);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_word(tok[0]);
    chk("slip_count", slip_cnt, 3);
    for (int i = 0; i < 1030; i++) send_word(tok[0]);
    chk("slip_lost_lock", lost, 1);
    do_reset();
    chk("slip_cleared", slip_cnt, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
